// File: rtl/cnn_pkg.sv
// Shared defaults and FSM state type for the CNN patch fetch datapath.
package cnn_pkg;

    localparam int unsigned IMG_W_DEF  = 28;
    localparam int unsigned IMG_H_DEF  = 28;
    localparam int unsigned K_DEF      = 3;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StHold
    } pfu_state_e;

endpackage

// File: rtl/patch_addr_gen.sv
// Maps a linear tap index plus latched centre to an image address and bounds flag.
module patch_addr_gen
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned K      = K_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned TW     = $clog2(K * K + 1)
) (
    input  logic [TW-1:0]             tap,
    input  logic [$clog2(IMG_W)-1:0]  cx,
    input  logic [$clog2(IMG_H)-1:0]  cy,
    output logic [ADDR_W-1:0]         addr,
    output logic                      in_bounds,
    output logic                      last_tap
);

    localparam int Half = int'(K / 2);

    int row;
    int col;
    int x;
    int y;

    // Signed coordinates so taps left of / above the image compare as negative.
    always_comb begin
        row       = int'(tap) / int'(K);
        col       = int'(tap) % int'(K);
        x         = int'(cx) + col - Half;
        y         = int'(cy) + row - Half;
        in_bounds = (x >= 0) && (x < int'(IMG_W)) && (y >= 0) && (y < int'(IMG_H));
        addr      = '0;
        if (in_bounds) begin
            addr = ADDR_W'(y * int'(IMG_W) + x);
        end
    end

    assign last_tap = (int'(tap) == int'(K * K) - 1);

endmodule

// File: rtl/patch_fetch_unit.sv
// Fetches a KxK pixel patch around a centre from a 1-cycle-latency memory.
module patch_fetch_unit
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned K      = K_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned PAD_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(IMG_W)-1:0]   cx,
    input  logic [$clog2(IMG_H)-1:0]   cy,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic [K*K*DATA_W-1:0]      patch,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       err
);

    localparam int unsigned KK   = K * K;
    localparam int unsigned TW   = $clog2(KK + 1);
    localparam int          Half = int'(K / 2);

    pfu_state_e                 state_q, state_d;
    logic [TW-1:0]              tap_q, tap_d;
    logic [$clog2(IMG_W)-1:0]   cx_q, cx_d;
    logic [$clog2(IMG_H)-1:0]   cy_q, cy_d;
    logic [KK*DATA_W-1:0]       patch_q, patch_d;
    logic [TW-1:0]              cap_idx_q, cap_idx_d;
    logic                       cap_en_q, cap_en_d;
    logic                       cap_inb_q, cap_inb_d;
    logic                       err_q, err_d;

    logic [ADDR_W-1:0]          gen_addr;
    logic                       gen_in_bounds;
    logic                       gen_last_tap;
    logic                       reject;

    patch_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .ADDR_W (ADDR_W),
        .TW     (TW)
    ) u_addr_gen (
        .tap       (tap_q),
        .cx        (cx_q),
        .cy        (cy_q),
        .addr      (gen_addr),
        .in_bounds (gen_in_bounds),
        .last_tap  (gen_last_tap)
    );

    always_comb begin
        reject = 1'b0;
        if (PAD_EN == 0) begin
            reject = (int'(cx) < Half) || (int'(cx) > int'(IMG_W) - 1 - Half) ||
                     (int'(cy) < Half) || (int'(cy) > int'(IMG_H) - 1 - Half);
        end
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        patch_d   = patch_q;
        cap_en_d  = 1'b0;
        cap_idx_d = tap_q;
        cap_inb_d = gen_in_bounds;
        err_d     = 1'b0;

        // Read data arrives one cycle after its tap issued; padded taps land as zero.
        if (cap_en_q) begin
            patch_d[cap_idx_q * DATA_W +: DATA_W] = cap_inb_q ? mem_rdata : '0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StFetch;
                        tap_d   = '0;
                        cx_d    = cx;
                        cy_d    = cy;
                        patch_d = '0;
                    end
                end
            end
            StFetch: begin
                cap_en_d = 1'b1;
                if (gen_last_tap) begin
                    state_d = StDrain;
                    tap_d   = '0;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            StDrain: state_d = StHold;
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            tap_q     <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            patch_q   <= '0;
            cap_idx_q <= '0;
            cap_en_q  <= 1'b0;
            cap_inb_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            patch_q   <= patch_d;
            cap_idx_q <= cap_idx_d;
            cap_en_q  <= cap_en_d;
            cap_inb_q <= cap_inb_d;
            err_q     <= err_d;
        end
    end

    assign mem_rd_en = (state_q == StFetch) && gen_in_bounds;
    assign mem_addr  = mem_rd_en ? gen_addr : '0;
    assign patch     = patch_q;
    assign out_valid = (state_q == StHold);
    assign busy      = (state_q != StIdle);
    assign err       = err_q;

endmodule

// File: tb/tb_patch_fetch_unit.sv
// Bench for patch_fetch_unit: padded and non-padded instances share stimulus and
// are compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_patch_fetch_unit;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int K  = 3;
    localparam int KK = K * K;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int PW = KK * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [4:0]    cx = '0;
    logic [4:0]    cy = '0;
    logic          rd_en [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] rdata [2];
    logic [PW-1:0] patch [2];
    logic          valid [2];
    logic          busy  [2];
    logic          err   [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    patch_fetch_unit #(
        .IMG_W(W), .IMG_H(H), .K(K), .DATA_W(DW), .ADDR_W(AW), .PAD_EN(1)
    ) dut_pad (
        .clk(clk), .rst(rst), .start(start), .cx(cx), .cy(cy),
        .mem_rd_en(rd_en[0]), .mem_addr(addr[0]), .mem_rdata(rdata[0]),
        .patch(patch[0]), .out_valid(valid[0]), .out_ready(out_ready),
        .busy(busy[0]), .err(err[0])
    );

    patch_fetch_unit #(
        .IMG_W(W), .IMG_H(H), .K(K), .DATA_W(DW), .ADDR_W(AW), .PAD_EN(0)
    ) dut_nopad (
        .clk(clk), .rst(rst), .start(start), .cx(cx), .cy(cy),
        .mem_rd_en(rd_en[1]), .mem_addr(addr[1]), .mem_rdata(rdata[1]),
        .patch(patch[1]), .out_valid(valid[1]), .out_ready(out_ready),
        .busy(busy[1]), .err(err[1])
    );

    // mem[a] = a[7:0]; junk when not read so stray captures show up.
    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            rdata[j] <= rd_en[j] ? addr[j][7:0] : DW'($urandom);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int tap_addr(input int px, input int py, input int i);
        int x;
        int y;
        x = px + i % K - K / 2;
        y = py + i / K - K / 2;
        if (x < 0 || x >= W || y < 0 || y >= H) return -1;
        return y * W + x;
    endfunction

    function automatic bit [PW-1:0] exp_patch(input int px, input int py);
        bit [PW-1:0] p;
        int ta;
        p = '0;
        for (int i = 0; i < KK; i++) begin
            ta = tap_addr(px, py, i);
            if (ta >= 0) p[i*DW +: DW] = DW'(ta % 256);
        end
        return p;
    endfunction

    function automatic bit rejected(input int px, input int py, input int pad);
        return (pad == 0) && (px < K / 2 || px > W - 1 - K / 2 || py < K / 2 || py > H - 1 - K / 2);
    endfunction

    function automatic bit [PW-1:0] pack(input int e[KK]);
        bit [PW-1:0] p;
        for (int i = 0; i < KK; i++) p[i*DW +: DW] = DW'(e[i]);
        return p;
    endfunction

    // Transaction model: cycles since accept decide which tap issues and which slots are filled.
    bit          m_busy  [2];
    bit          m_valid [2];
    bit          m_err   [2];
    int          m_cyc   [2];
    int          m_cx    [2];
    int          m_cy    [2];
    bit [PW-1:0] m_full  [2];
    bit [PW-1:0] m_shown [2];

    always @(posedge clk or negedge rst) begin
        for (int j = 0; j < 2; j++) begin
            if (!rst) begin
                m_busy[j] = 0; m_valid[j] = 0; m_err[j] = 0; m_cyc[j] = 0;
                m_shown[j] = '0;
            end else begin
                m_err[j] = 0;
                if (!m_busy[j]) begin
                    if (start) begin
                        if (rejected(int'(cx), int'(cy), (j == 0) ? 1 : 0)) begin
                            m_err[j] = 1;
                        end else begin
                            m_busy[j] = 1;
                            m_cyc[j]  = 1;
                            m_cx[j]   = int'(cx);
                            m_cy[j]   = int'(cy);
                            m_full[j] = exp_patch(int'(cx), int'(cy));
                        end
                    end
                end else if (m_valid[j]) begin
                    if (out_ready) begin
                        m_busy[j]  = 0;
                        m_valid[j] = 0;
                    end
                end else begin
                    m_cyc[j]++;
                    if (m_cyc[j] == KK + 2) begin
                        m_valid[j] = 1;
                        m_shown[j] = m_full[j];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            int          cnt;
            int          ta;
            bit [PW-1:0] ep;
            bit          erd;
            bit [AW-1:0] ea;
            erd = 0;
            ea  = '0;
            ep  = m_shown[j];
            if (m_busy[j]) begin
                cnt = m_cyc[j] - 2;
                ep  = '0;
                for (int i = 0; i < KK; i++) begin
                    if (i < cnt) ep[i*DW +: DW] = m_full[j][i*DW +: DW];
                end
                if (!m_valid[j] && m_cyc[j] <= KK) begin
                    ta = tap_addr(m_cx[j], m_cy[j], m_cyc[j] - 1);
                    if (ta >= 0) begin
                        erd = 1;
                        ea  = AW'(ta);
                    end
                end
            end
            chk($sformatf("rd_en%0d", j), rd_en[j], erd);
            chk($sformatf("addr%0d", j), addr[j], ea);
            chk($sformatf("patch%0d", j), patch[j], ep);
            chk($sformatf("valid%0d", j), valid[j], m_valid[j]);
            chk($sformatf("busy%0d", j), busy[j], m_busy[j]);
            chk($sformatf("err%0d", j), err[j], m_err[j]);
        end
    end

    int rdq[$];
    int nrd1 = 0;

    always @(negedge clk) begin
        if (rd_en[0]) rdq.push_back(int'(addr[0]));
        if (rd_en[1]) nrd1++;
    end

    task automatic fetch(input int px, input int py, output int lat);
        rdq.delete();
        nrd1 = 0;
        @(negedge clk);
        start = 1'b1;
        cx    = 5'(px);
        cy    = 5'(py);
        lat   = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid[0]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic chk_reads(input string name, input int e[KK], input int n);
        chk({name, " count"}, rdq.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s rd%0d", name, i), (i < rdq.size()) ? rdq[i] : -1, e[i]);
        end
    endtask

    task automatic chk_slots(input string name, input int e[KK]);
        for (int i = 0; i < KK; i++) begin
            chk($sformatf("%s slot%0d", name, i), patch[0][i*DW +: DW], e[i]);
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handshake valid", valid[0], 0);
        chk("handshake busy", busy[0], 0);
    endtask

    task automatic chk_all_zero(input string name);
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("%s rd_en%0d", name, j), rd_en[j], 0);
            chk($sformatf("%s addr%0d", name, j), addr[j], 0);
            chk($sformatf("%s patch%0d", name, j), patch[j], 0);
            chk($sformatf("%s valid%0d", name, j), valid[j], 0);
            chk($sformatf("%s busy%0d", name, j), busy[j], 0);
            chk($sformatf("%s err%0d", name, j), err[j], 0);
        end
    endtask

    int exp21[KK]  = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    int rd22[KK]   = '{0, 1, 28, 29, 0, 0, 0, 0, 0};
    int sl22[KK]   = '{0, 0, 0, 0, 0, 1, 0, 28, 29};
    int rd23[KK]   = '{754, 755, 782, 783, 0, 0, 0, 0, 0};
    int sl23[KK]   = '{242, 243, 0, 14, 15, 0, 0, 0, 0};
    int edges[4]   = '{0, 1, 26, 27};

    initial begin
        int lat;

        #1 rst = 1'b0;
        #2 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Interior fetch, then backpressure with an ignored start in HOLD.
        fetch(1, 1, lat);
        chk("req021 latency", lat, 11);
        chk_reads("req021", exp21, 9);
        chk_slots("req021", exp21);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            start = (n == 2);
            cx    = 5'd5;
            cy    = 5'd5;
            chk("bp valid", valid[0], 1);
            chk("bp patch", patch[0], pack(exp21));
        end
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        chk("bp idle valid", valid[0], 0);
        chk("bp idle busy", busy[0], 0);
        chk("bp kept patch", patch[0], pack(exp21));

        fetch(0, 0, lat);
        chk("req022 latency", lat, 11);
        chk_reads("req022", rd22, 4);
        chk_slots("req022", sl22);
        handshake();

        fetch(27, 27, lat);
        chk_reads("req023", rd23, 4);
        chk_slots("req023", sl23);
        handshake();

        // Non-padded instance rejects an edge centre.
        nrd1 = 0;
        @(negedge clk);
        start = 1'b1;
        cx    = 5'd0;
        cy    = 5'd5;
        @(negedge clk);
        start = 1'b0;
        chk("req024 err", err[1], 1);
        chk("req024 busy", busy[1], 0);
        chk("req024 pad err", err[0], 0);
        @(negedge clk);
        chk("req024 err pulse", err[1], 0);
        for (int n = 0; n < 20 && !valid[0]; n++) @(negedge clk);
        chk("req024 no reads", nrd1, 0);
        handshake();

        // Reset in the middle of FETCH abandons the transaction.
        @(negedge clk);
        start = 1'b1;
        cx    = 5'd1;
        cy    = 5'd1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1 chk_all_zero("req026");
        @(negedge clk);
        rst = 1'b1;
        fetch(1, 1, lat);
        chk("req026 latency", lat, 11);
        chk_reads("req026", exp21, 9);
        chk_slots("req026", exp21);
        handshake();

        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                cx = 5'($urandom_range(0, W - 1));
                cy = 5'($urandom_range(0, H - 1));
            end else begin
                cx = 5'(edges[$urandom_range(0, 3)]);
                cy = 5'($urandom_range(0, 1) == 1 ? edges[$urandom_range(0, 3)]
                                                  : $urandom_range(0, H - 1));
            end
            out_ready = ($urandom_range(0, 2) == 0);
            if (n == 700) begin
                #2 rst = 1'b0;
                #2 rst = 1'b1;
            end
        end

        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
